// File: rtl/mini_alu_core_param.sv
// Parametrised two-stage mini ALU core (IF/EX) with external ROM fetch.
// Define MINI_ALU_SEQ_MUL_EN for the stalling shift-add MUL; default is a one-cycle MUL.
module mini_alu_core_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [IP_W-1:0]       oIP,
    input  logic [3*ADDR_W+3:0]   iInstruction,
    output logic [LED_W-1:0]      oLed,
    output logic                  oBusy,
    output logic                  oHalted
);

    localparam int IW    = 3*ADDR_W + 4;
    localparam int DEPTH = 2**ADDR_W;
    localparam int PW    = 2*DATA_W;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LED  = 4'd1;
    localparam logic [3:0] OP_BLE  = 4'd2;
    localparam logic [3:0] OP_STO  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SMUL = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd9;

    logic [IP_W-1:0]   r_ip;
    logic [IW-1:0]     r_ir;
    logic [LED_W-1:0]  r_led;
    logic              r_halted;
    logic [DATA_W-1:0] r_rf [DEPTH];

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_dst;
    logic [ADDR_W-1:0] w_src1;
    logic [ADDR_W-1:0] w_src0;
    logic [DATA_W-1:0] w_a0;
    logic [DATA_W-1:0] w_a1;
    logic [DATA_W-1:0] w_imm;
    logic [IP_W-1:0]   w_tgt;
    logic [DATA_W-1:0] w_smul;

    logic [IP_W-1:0]   w_ip_nxt;
    logic [IW-1:0]     w_ir_nxt;
    logic [LED_W-1:0]  w_led_nxt;
    logic              w_halt_nxt;
    logic              w_we0;
    logic              w_we1;
    logic [ADDR_W-1:0] w_wa0;
    logic [ADDR_W-1:0] w_wa1;
    logic [DATA_W-1:0] w_wd0;
    logic [DATA_W-1:0] w_wd1;

    assign w_op   = r_ir[3*ADDR_W+3:3*ADDR_W];
    assign w_dst  = r_ir[3*ADDR_W-1:2*ADDR_W];
    assign w_src1 = r_ir[2*ADDR_W-1:ADDR_W];
    assign w_src0 = r_ir[ADDR_W-1:0];
    assign w_a0   = r_rf[w_src0];
    assign w_a1   = r_rf[w_src1];
    assign w_imm  = DATA_W'({w_src1, w_src0});
    assign w_tgt  = IP_W'(w_dst);

`ifdef MINI_ALU_SEQ_MUL_EN
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WBLO,
        S_WBHI
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_mc;
    logic [DATA_W-1:0] r_mp;
    logic [PW-1:0]   r_prod;
    logic [CW-1:0]   r_cnt;
    logic            w_mul_start;

    assign w_smul      = w_a0 * w_a1;
    assign w_mul_start = !r_halted && (r_state == S_IDLE) && (w_op == OP_MUL);
    assign oBusy       = (r_state != S_IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift-add: multiplicand moves left, multiplier right, one bit per BUSY cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mc   <= '0;
            r_mp   <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (w_mul_start) begin
            r_mc   <= PW'(w_a0);
            r_mp   <= w_a1;
            r_prod <= '0;
            r_cnt  <= CW'(DATA_W);
        end else if (r_state == S_BUSY) begin
            if (r_mp[0]) begin
                r_prod <= r_prod + r_mc;
            end
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
            r_cnt <= r_cnt - CW'(1);
        end
    end
`else
    logic [PW-1:0] w_prod;

    assign w_prod = PW'(w_a0) * PW'(w_a1);
    assign w_smul = w_prod[DATA_W-1:0];
    assign oBusy  = 1'b0;
`endif

    always_comb begin
        w_ip_nxt   = r_ip + IP_W'(1);
        w_ir_nxt   = iInstruction;
        w_led_nxt  = r_led;
        w_halt_nxt = r_halted;
        w_we0      = 1'b0;
        w_we1      = 1'b0;
        w_wa0      = w_dst;
        w_wa1      = w_dst + ADDR_W'(1);
        w_wd0      = '0;
        w_wd1      = '0;
`ifdef MINI_ALU_SEQ_MUL_EN
        w_state_nxt = r_state;
`endif
        if (r_halted) begin
            w_ip_nxt = r_ip;
            w_ir_nxt = r_ir;
        end
`ifdef MINI_ALU_SEQ_MUL_EN
        else if ((r_state != S_IDLE) || (w_op == OP_MUL)) begin
            w_ip_nxt = r_ip;
            w_ir_nxt = r_ir;
            unique case (r_state)
                S_IDLE: w_state_nxt = S_BUSY;
                S_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        w_state_nxt = S_WBLO;
                    end
                end
                S_WBLO: begin
                    w_we0       = 1'b1;
                    w_wd0       = r_prod[DATA_W-1:0];
                    w_state_nxt = S_WBHI;
                end
                S_WBHI: begin
                    w_we1       = 1'b1;
                    w_wd1       = r_prod[PW-1:DATA_W];
                    w_state_nxt = S_IDLE;
                    w_ip_nxt    = r_ip + IP_W'(1);
                    w_ir_nxt    = iInstruction;
                end
            endcase
        end
`endif
        else begin
            unique case (w_op)
                OP_LED: w_led_nxt = LED_W'(w_a1);
                OP_BLE: begin
                    if (w_a1 <= w_a0) begin
                        w_ip_nxt = w_tgt;
                        w_ir_nxt = '0;
                    end
                end
                OP_STO: begin
                    w_we0 = 1'b1;
                    w_wd0 = w_imm;
                end
                OP_ADD: begin
                    w_we0 = 1'b1;
                    w_wd0 = w_a0 + w_a1;
                end
                OP_JMP: begin
                    w_ip_nxt = w_tgt;
                    w_ir_nxt = '0;
                end
                OP_SUB: begin
                    w_we0 = 1'b1;
                    w_wd0 = w_a0 - w_a1;
                end
                OP_SMUL: begin
                    w_we0 = 1'b1;
                    w_wd0 = w_smul;
                end
`ifndef MINI_ALU_SEQ_MUL_EN
                OP_MUL: begin
                    w_we0 = 1'b1;
                    w_wd0 = w_prod[DATA_W-1:0];
                    w_we1 = 1'b1;
                    w_wd1 = w_prod[PW-1:DATA_W];
                end
`endif
                OP_HLT: begin
                    w_halt_nxt = 1'b1;
                    w_ip_nxt   = r_ip;
                    w_ir_nxt   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ip     <= '0;
            r_ir     <= {OP_NOP, {(3*ADDR_W){1'b0}}};
            r_led    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_ip     <= w_ip_nxt;
            r_ir     <= w_ir_nxt;
            r_led    <= w_led_nxt;
            r_halted <= w_halt_nxt;
        end
    end

    // Register file has no reset; Reset only suppresses writes.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (w_we0) begin
                r_rf[w_wa0] <= w_wd0;
            end
            if (w_we1) begin
                r_rf[w_wa1] <= w_wd1;
            end
        end
    end

    assign oIP     = r_ip;
    assign oLed    = r_led;
    assign oHalted = r_halted;

endmodule

// File: tb/tb_mini_alu_core_param.sv
// Scoreboard bench for mini_alu_core_param: LED outputs are queued and
// popped by a monitor; pipeline timing and registers are checked directly.
module tb_mini_alu_core_param;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int IP_W   = 16;
    localparam int LED_W  = 8;

`ifdef MINI_ALU_SEQ_MUL_EN
    localparam int EXP_BUSY = DATA_W + 2;
    localparam int EXP_IP22 = 4;
`else
    localparam int EXP_BUSY = 0;
    localparam int EXP_IP22 = 22;
`endif

    logic                Clock;
    logic                Reset;
    logic [IP_W-1:0]     oIP;
    logic [3*ADDR_W+3:0] iInstruction;
    logic [LED_W-1:0]    oLed;
    logic                oBusy;
    logic                oHalted;

    logic [27:0] rom [256];
    logic [7:0]  sb [$];
    int          checks;
    int          errors;

    mini_alu_core_param #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .IP_W  (IP_W),
        .LED_W (LED_W)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .oIP         (oIP),
        .iInstruction(iInstruction),
        .oLed        (oLed),
        .oBusy       (oBusy),
        .oHalted     (oHalted)
    );

    assign iInstruction = rom[oIP[7:0]];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] enc(logic [3:0] op, logic [7:0] d,
                                        logic [7:0] s1, logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    function automatic logic [27:0] sto(logic [7:0] d, logic [15:0] imm);
        return {4'd3, d, imm};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic enter_reset();
        @(negedge Clock);
        #1 Reset = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic release_reset();
        tick(2);
        #1 Reset = 1'b0;
    endtask

    // Monitor: every change of oLed outside reset consumes one expected value.
    initial begin
        logic [7:0] prev;
        logic [7:0] exp;
        prev = '0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                prev = oLed;
            end else if (oLed !== prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL led_unexpected got %h want none", oLed);
                end else begin
                    exp = sb.pop_front();
                    check("led_sb", 32'(oLed), 32'(exp));
                end
                prev = oLed;
            end
        end
    end

    initial begin
        int busy;
        int ipbad;
        checks = 0;
        errors = 0;
        Reset  = 1'b1;

        // Arithmetic, forwarding-free back-to-back dependency, wrap-around
        enter_reset();
        rom[0]  = sto(8'd1, 16'd5);
        rom[1]  = sto(8'd2, 16'd3);
        rom[2]  = enc(4'd4, 8'd3, 8'd2, 8'd1);
        rom[3]  = enc(4'd1, 8'd0, 8'd3, 8'd0);
        rom[4]  = enc(4'd6, 8'd4, 8'd1, 8'd2);
        rom[5]  = sto(8'd1, 16'd7);
        rom[6]  = enc(4'd4, 8'd2, 8'd1, 8'd1);
        rom[7]  = enc(4'd1, 8'd0, 8'd2, 8'd0);
        rom[8]  = enc(4'd7, 8'd6, 8'd3, 8'd2);
        rom[9]  = enc(4'd1, 8'd0, 8'd6, 8'd0);
        rom[10] = sto(8'd7, 16'hFFFF);
        rom[11] = sto(8'd8, 16'h0002);
        rom[12] = enc(4'd4, 8'd9, 8'd8, 8'd7);
        rom[13] = enc(4'd1, 8'd0, 8'd9, 8'd0);
        sb.push_back(8'h08);
        sb.push_back(8'h0E);
        sb.push_back(8'h70);
        sb.push_back(8'h01);
        release_reset();
        check("rst_ip", 32'(oIP), 32'd0);
        check("rst_led", 32'(oLed), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_halt", 32'(oHalted), 32'd0);
        tick(1);
        check("ip_1", 32'(oIP), 32'd1);
        tick(1);
        check("ip_2", 32'(oIP), 32'd2);
        tick(1);
        check("ip_3", 32'(oIP), 32'd3);
        tick(5);
        check("ip_8", 32'(oIP), 32'd8);
        check("dep_r2", 32'(dut.r_rf[2]), 32'd14);
        check("sto_r1", 32'(dut.r_rf[1]), 32'd7);
        tick(10);
        check("add_r3", 32'(dut.r_rf[3]), 32'd8);
        check("sub_r4", 32'(dut.r_rf[4]), 32'hFFFE);
        check("smul_r6", 32'(dut.r_rf[6]), 32'h70);
        check("wrap_r9", 32'(dut.r_rf[9]), 32'h1);

        // Counting loop with BLE: one bubble per taken branch
        enter_reset();
        rom[0] = sto(8'd1, 16'd0);
        rom[1] = sto(8'd2, 16'd1);
        rom[2] = sto(8'd3, 16'd3);
        rom[3] = enc(4'd4, 8'd1, 8'd2, 8'd1);
        rom[4] = enc(4'd2, 8'd3, 8'd1, 8'd3);
        rom[5] = enc(4'd1, 8'd0, 8'd1, 8'd0);
        sb.push_back(8'h04);
        release_reset();
        tick(6);
        check("ble_tgt_ip", 32'(oIP), 32'd3);
        tick(1);
        check("ble_next_ip", 32'(oIP), 32'd4);
        tick(8);
        check("loop_led_early", 32'(oLed), 32'd0);
        tick(1);
        check("loop_led_time", 32'(oLed), 32'd4);
        check("loop_r1", 32'(dut.r_rf[1]), 32'd4);

        // MUL with both halves written
        enter_reset();
        rom[0] = sto(8'd1, 16'h1234);
        rom[1] = sto(8'd2, 16'h0100);
        rom[2] = enc(4'd8, 8'd4, 8'd2, 8'd1);
        rom[3] = enc(4'd1, 8'd0, 8'd5, 8'd0);
        sb.push_back(8'h12);
        release_reset();
        busy  = 0;
        ipbad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (oBusy) begin
                busy++;
                if (oIP !== 16'd3) ipbad++;
            end
            if (i == 22) check("mul_ip_after", 32'(oIP), 32'(EXP_IP22));
        end
        check("mul_busy_cycles", 32'(busy), 32'(EXP_BUSY));
        check("mul_ip_frozen", 32'(ipbad), 32'd0);
        check("mul_r4", 32'(dut.r_rf[4]), 32'h3400);
        check("mul_r5", 32'(dut.r_rf[5]), 32'h0012);

`ifdef MINI_ALU_SEQ_MUL_EN
        // Reset in the 5th BUSY cycle must abandon the multiply
        enter_reset();
        rom[0] = sto(8'd4, 16'hAAAA);
        rom[1] = sto(8'd5, 16'hBBBB);
        rom[2] = sto(8'd1, 16'h1234);
        rom[3] = sto(8'd2, 16'h0100);
        rom[4] = enc(4'd8, 8'd4, 8'd2, 8'd1);
        release_reset();
        tick(10);
        check("mid_busy_before", 32'(oBusy), 32'd1);
        #1 Reset = 1'b1;
        tick(1);
        check("mid_busy_after", 32'(oBusy), 32'd0);
        check("mid_ip", 32'(oIP), 32'd0);
        tick(25);
        check("mid_r4", 32'(dut.r_rf[4]), 32'hAAAA);
        check("mid_r5", 32'(dut.r_rf[5]), 32'hBBBB);
`endif

        // HLT at address 6 freezes fetch and suppresses later instructions
        enter_reset();
        rom[0] = sto(8'd1, 16'h0021);
        rom[1] = enc(4'd1, 8'd0, 8'd1, 8'd0);
        rom[6] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        rom[7] = sto(8'd1, 16'h0099);
        rom[8] = enc(4'd1, 8'd0, 8'd1, 8'd0);
        sb.push_back(8'h21);
        release_reset();
        tick(7);
        check("hlt_before", 32'(oHalted), 32'd0);
        tick(1);
        check("hlt_set", 32'(oHalted), 32'd1);
        check("hlt_ip", 32'(oIP), 32'd7);
        tick(12);
        check("hlt_ip_hold", 32'(oIP), 32'd7);
        check("hlt_still", 32'(oHalted), 32'd1);
        check("hlt_no_write", 32'(dut.r_rf[1]), 32'h21);

        tick(2);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
